// File: rtl/door_lock_if.sv
// Keypad/lock signal bundle between the debounce stages and the code-entry controller.
interface door_lock_if;
  logic [3:0] digit_p;
  logic       enter_p;
  logic       lock_p;
  logic       unlocked;
  logic       alarm;
  logic       err_p;
  logic [2:0] digit_cnt;

  modport master (
    output digit_p, enter_p, lock_p,
    input  unlocked, alarm, err_p, digit_cnt
  );

  modport slave (
    input  digit_p, enter_p, lock_p,
    output unlocked, alarm, err_p, digit_cnt
  );
endinterface

// File: rtl/door_lock_ctrl.sv
// Door lock code-entry controller: collects 4 keypad digits, opens on the right code,
// and locks the keypad out for a fixed time after MAX_FAIL consecutive wrong codes.
module door_lock_ctrl #(
  parameter logic [7:0]  CODE          = 8'b00_01_10_11,
  parameter int unsigned UNLOCK_TICKS  = 950,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCKOUT_TICKS = 5700
) (
  input  logic        Clk190,
  input  logic        Reset,
  door_lock_if.slave  i_kp
);

  typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, LOCKOUT = 2'd2} state_t;

  localparam logic [2:0]  FAIL_MAX  = 3'(MAX_FAIL);
  localparam logic [15:0] OPEN_LOAD = 16'(UNLOCK_TICKS - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_TICKS - 1);

  state_t      r_state,     w_state_nxt;
  logic [7:0]  r_entry,     w_entry_nxt;
  logic [2:0]  r_digit_cnt, w_digit_cnt_nxt;
  logic [2:0]  r_fail_cnt,  w_fail_cnt_nxt;
  logic [15:0] r_timer,     w_timer_nxt;
  logic        r_unlocked,  r_alarm, r_err, w_err_nxt;
  logic [2:0]  w_fail_inc;
  logic [1:0]  w_index;
  logic        w_onehot;

  always_comb begin
    w_onehot = $onehot(i_kp.digit_p);
    unique case (1'b1)
      i_kp.digit_p[1]: w_index = 2'd1;
      i_kp.digit_p[2]: w_index = 2'd2;
      i_kp.digit_p[3]: w_index = 2'd3;
      default:         w_index = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_entry_nxt     = r_entry;
    w_digit_cnt_nxt = r_digit_cnt;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_timer_nxt     = r_timer;
    w_err_nxt       = 1'b0;
    w_fail_inc      = (r_fail_cnt >= FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 3'd1;

    unique case (r_state)
      IDLE: begin
        // enter outranks a digit pulse landing in the same cycle
        if (i_kp.enter_p) begin
          w_entry_nxt     = 8'd0;
          w_digit_cnt_nxt = 3'd0;
          if (r_digit_cnt == 3'd4 && r_entry == CODE) begin
            w_state_nxt    = OPEN;
            w_timer_nxt    = OPEN_LOAD;
            w_fail_cnt_nxt = 3'd0;
          end else begin
            w_err_nxt      = 1'b1;
            w_fail_cnt_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_MAX) begin
              w_state_nxt = LOCKOUT;
              w_timer_nxt = LOCK_LOAD;
            end
          end
        end else if (i_kp.lock_p) begin
          w_entry_nxt     = 8'd0;
          w_digit_cnt_nxt = 3'd0;
        end else if (w_onehot && r_digit_cnt < 3'd4) begin
          w_entry_nxt     = {r_entry[5:0], w_index};
          w_digit_cnt_nxt = r_digit_cnt + 3'd1;
        end
      end
      OPEN: begin
        if (i_kp.lock_p || r_timer == 16'd0) begin
          w_state_nxt = IDLE;
          w_timer_nxt = 16'd0;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      LOCKOUT: begin
        if (r_timer == 16'd0) begin
          w_state_nxt    = IDLE;
          w_fail_cnt_nxt = 3'd0;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clk190 or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_entry     <= 8'd0;
      r_digit_cnt <= 3'd0;
      r_fail_cnt  <= 3'd0;
      r_timer     <= 16'd0;
      r_unlocked  <= 1'b0;
      r_alarm     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_entry     <= w_entry_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_unlocked  <= (w_state_nxt == OPEN);
      r_alarm     <= (w_state_nxt == LOCKOUT);
      r_err       <= w_err_nxt;
    end
  end

  assign i_kp.unlocked  = r_unlocked;
  assign i_kp.alarm     = r_alarm;
  assign i_kp.err_p     = r_err;
  assign i_kp.digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl with default parameters (code 0,1,2,3).
module tb_door_lock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  door_lock_if kp();

  door_lock_ctrl dut (
    .Clk190 (clk),
    .Reset  (rst),
    .i_kp   (kp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of pulses, land 1 time unit after the sampling edge
  task automatic step(input logic [3:0] d, input logic e, input logic l);
    @(negedge clk);
    kp.digit_p = d;
    kp.enter_p = e;
    kp.lock_p  = l;
    @(posedge clk);
    #1;
    kp.digit_p = 4'd0;
    kp.enter_p = 1'b0;
    kp.lock_p  = 1'b0;
  endtask

  task automatic digits(input logic [7:0] c);
    for (int i = 3; i >= 0; i--) begin
      logic [1:0] dg;
      dg = c[2*i +: 2];
      step(4'b0001 << dg, 1'b0, 1'b0);
    end
  endtask

  task automatic enter_code(input logic [7:0] c);
    digits(c);
    step(4'd0, 1'b1, 1'b0);
  endtask

  task automatic measure_open(output int n);
    n = 0;
    while (kp.unlocked && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  int n;
  bit sticky;

  initial begin
    kp.digit_p = 4'd0;
    kp.enter_p = 1'b0;
    kp.lock_p  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_unlocked", kp.unlocked, 0);
    chk("rst_alarm", kp.alarm, 0);
    chk("rst_err", kp.err_p, 0);
    chk("rst_cnt", kp.digit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // correct code, digit count stepping, full open duration
    step(4'b0001, 0, 0); chk("cnt1", kp.digit_cnt, 1);
    step(4'b0010, 0, 0); chk("cnt2", kp.digit_cnt, 2);
    step(4'b0100, 0, 0); chk("cnt3", kp.digit_cnt, 3);
    step(4'b1000, 0, 0); chk("cnt4", kp.digit_cnt, 4);
    step(4'd0, 1, 0);
    chk("open_cnt0", kp.digit_cnt, 0);
    chk("open_unlocked", kp.unlocked, 1);
    chk("open_err", kp.err_p, 0);
    measure_open(n);
    chk("open_ticks", n, 950);
    chk("closed_after", kp.unlocked, 0);

    // three wrong codes -> lockout
    for (int k = 1; k <= 3; k++) begin
      enter_code(8'b00_01_10_10);
      chk("wrong_err", kp.err_p, 1);
      chk("wrong_unlocked", kp.unlocked, 0);
      chk("wrong_cnt", kp.digit_cnt, 0);
      chk("wrong_alarm", kp.alarm, (k == 3) ? 1 : 0);
      if (k < 3) begin
        step(4'd0, 0, 0);
        chk("err_one_cycle", kp.err_p, 0);
      end
    end
    n = kp.alarm ? 1 : 0;
    sticky = 1'b0;
    while (kp.alarm && n < 7000) begin
      step(4'b0001 << (n % 4), (n % 5) == 0, (n % 7) == 0);
      if (kp.alarm) begin
        n++;
        if (kp.unlocked || kp.err_p || kp.digit_cnt != 3'd0) sticky = 1'b1;
      end
    end
    chk("lockout_ticks", n, 5700);
    chk("lockout_ignored", int'(sticky), 0);
    chk("lockout_cnt", kp.digit_cnt, 0);

    // correct code after lockout, digits ignored while open, lock_p closes
    enter_code(8'b00_01_10_11);
    chk("post_lock_open", kp.unlocked, 1);
    for (int k = 0; k < 10; k++) step(4'b0100, 0, 0);
    chk("open_digits_ignored", kp.digit_cnt, 0);
    chk("still_open", kp.unlocked, 1);
    step(4'd0, 0, 1);
    chk("lock_p_closes", kp.unlocked, 0);

    // multi-bit digit ignored, fifth digit ignored
    step(4'b0011, 0, 0); chk("multi_ignored", kp.digit_cnt, 0);
    digits(8'b00_01_10_11);
    step(4'b0001, 0, 0); chk("fifth_ignored", kp.digit_cnt, 4);
    step(4'd0, 1, 0);
    chk("fifth_open", kp.unlocked, 1);
    step(4'd0, 0, 1);

    // enter with a digit in the same cycle drops the digit: fail 1
    step(4'b0001, 0, 0);
    step(4'b0010, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b1000, 1, 0);
    chk("drop_err", kp.err_p, 1);
    chk("drop_cnt", kp.digit_cnt, 0);
    chk("drop_unlocked", kp.unlocked, 0);
    enter_code(8'b11_11_11_11);
    chk("fail2_alarm", kp.alarm, 0);
    enter_code(8'b00_01_10_11);
    chk("clear_open", kp.unlocked, 1);
    step(4'd0, 0, 1);
    enter_code(8'b01_01_01_01);
    enter_code(8'b01_01_01_01);
    chk("cleared_no_alarm", kp.alarm, 0);
    enter_code(8'b01_01_01_01);
    chk("third_alarm", kp.alarm, 1);

    // asynchronous reset mid-lockout
    #2 rst = 1'b1;
    #1;
    chk("arst_lock_alarm", kp.alarm, 0);
    chk("arst_lock_cnt", kp.digit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    enter_code(8'b00_01_10_11);
    chk("arst_reopen", kp.unlocked, 1);

    // asynchronous reset mid-open
    #2 rst = 1'b1;
    #1;
    chk("arst_open_unlocked", kp.unlocked, 0);
    chk("arst_open_alarm", kp.alarm, 0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 0, 0);
    step(4'b0010, 0, 0);
    chk("partial_cnt", kp.digit_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_entry_cnt", kp.digit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    enter_code(8'b00_01_10_11);
    chk("final_open", kp.unlocked, 1);
    step(4'd0, 0, 1);
    chk("final_closed", kp.unlocked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Code-entry controller for the door lock. It consumes the one-cycle pulses produced by the per-button debounce stages and collects a 4-digit code (digits 0–3). It drives the lock solenoid while the code is correct and enforces a timed lockout after repeated wrong entries. It sits between the debounced keypad inputs and the lock/LED outputs, all in the Clk190 domain.

## Interface
- CODE, 8'b00_01_10_11, secret code as four 2-bit digits; first digit entered is bits [7:6], last is bits [1:0].
- UNLOCK_TICKS, 950, cycles the door stays unlocked (5 s at 190 Hz); legal range 1..2^16-1.
- MAX_FAIL, 3, consecutive wrong entries that trigger lockout; legal range 1..7.
- LOCKOUT_TICKS, 5700, lockout duration in cycles (30 s); legal range 1..2^16-1.
- Clk190  input  1  system clock, 190 Hz.
- Reset  input  1  asynchronous, active-high.
- digit_p  input  4  one-cycle debounced pulses; bit i = digit i pressed.
- enter_p  input  1  one-cycle debounced "enter" pulse.
- lock_p  input  1  one-cycle debounced "lock now" pulse.
- unlocked  output  1  solenoid drive; high only in OPEN.
- alarm  output  1  high only in LOCKOUT.
- err_p  output  1  one-cycle pulse on each rejected entry.
- digit_cnt  output  3  digits collected so far, 0..4.

## Operation
- States: IDLE, OPEN, LOCKOUT. Reset drives state=IDLE, entry=0, digit_cnt=0, fail_cnt=0, timer=0, unlocked=0, alarm=0, err_p=0.
- IDLE, digit accept: digit_p is one-hot, enter_p=0, and digit_cnt<4 -> entry <= {entry[5:0], index}, digit_cnt+1.
- IDLE, ignored digits: digit_p with more than one bit set is ignored. Digits arriving when digit_cnt=4 are ignored.
- IDLE, enter_p: enter_p has priority over any digit_p in the same cycle; that digit is dropped.
- Correct code (digit_cnt=4 and entry==CODE): go to OPEN, load timer=UNLOCK_TICKS-1, clear fail_cnt.
- Wrong code: err_p=1 for one cycle and fail_cnt+1. If the new fail_cnt==MAX_FAIL, go to LOCKOUT and load timer=LOCKOUT_TICKS-1; otherwise stay in IDLE.
- Every enter_p, correct or wrong, clears entry and digit_cnt.
- IDLE, lock_p: clears entry and digit_cnt. It does not affect fail_cnt.
- OPEN: timer decrements each cycle. At timer==0 or on lock_p (lock_p wins if both), return to IDLE. digit_p and enter_p are ignored. entry and digit_cnt stay 0.
- LOCKOUT: all inputs are ignored. Timer decrements; at timer==0 go to IDLE and clear fail_cnt.
- Arithmetic: timer is 16-bit unsigned and never underflows. fail_cnt is 3-bit and saturates at MAX_FAIL.

## Timing
- All outputs are registered. An enter_p sampled at edge N produces unlocked/alarm/err_p valid after edge N.
- unlocked stays high for exactly UNLOCK_TICKS cycles when no lock_p arrives. alarm stays high for exactly LOCKOUT_TICKS cycles.
- lock_p sampled at edge M in OPEN: unlocked low after edge M.
- digit_cnt updates after the edge that samples the accepted digit_p.
- Reset asserted mid-operation (any state) forces all reset values immediately and asynchronously. The first input is accepted on the first edge after deassertion.
- Back-to-back pulses on consecutive cycles are each processed. The block has no internal pulse stretching or holdoff.

## Test plan
- Reset release, then digit_p 0001,0010,0100,1000 on separate cycles, then enter_p -> digit_cnt steps 1,2,3,4, then 0. unlocked=1 for exactly 950 cycles, then 0.
- Enter code 0,1,2,2 and enter_p -> err_p high for 1 cycle, unlocked stays 0, digit_cnt=0. Repeat twice more -> after the 3rd, alarm=1 for exactly 5700 cycles, with all pulses ignored. Then a correct code unlocks.
- Correct code, wait 10 cycles, lock_p -> unlocked falls after that edge. Any digit_p during OPEN leaves digit_cnt=0.
- digit_p=0011, and five one-hot digits (0,1,2,3,0) -> first ignored, fifth ignored. digit_cnt=4 and code accepted on enter_p.
- enter_p with digit_p=1000 in the same cycle after three correct digits -> digit dropped, err_p=1, fail_cnt=1. Two wrong entries then a correct one -> fail_cnt cleared, so three later wrong entries are needed for lockout.
- Reset pulse mid-OPEN and mid-LOCKOUT -> unlocked=0, alarm=0, digit_cnt=0 immediately. A correct code then unlocks normally.
